// File: rtl/async_fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
// DATA_WIDTH default mirrors the asynchronous FIFO's data width.
package async_fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_MAX_BURST   = 16;

  function automatic int grant_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // One extra bit so the beat count never wraps inside a burst.
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

  localparam int GRANT_W = grant_width(DEF_NUM_REQ);
  localparam int CNT_W   = cnt_width(DEF_MAX_BURST);

endpackage

// File: rtl/async_fifo_write_arbiter_rr_priority_picker.sv
// Round-robin picker: first asserted request strictly after last_grant,
// wrapping modulo NUM_REQ, so last_grant itself is considered last.
module rr_priority_picker
  import async_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int GW      = grant_width(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic [GW-1:0]      winner,
  output logic               any_req
);

  always_comb begin : pick
    int            idx;
    logic [GW-1:0] idx_g;
    idx     = 0;
    idx_g   = '0;
    winner  = '0;
    any_req = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_g = GW'(idx);
      if (!any_req && req[idx_g]) begin
        any_req = 1'b1;
        winner  = idx_g;
      end
    end
  end

endmodule

// File: rtl/async_fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready
// requesters; a grant lasts until LAST or MAX_BURST accepted beats.
module async_fifo_write_arbiter
  import async_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          WR_CLK,
  input  logic                          FRSTN,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_LAST,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic                          FIFO_FULL,
  output logic                          FIFO_WR_EN,
  output logic [DATA_WIDTH-1:0]         FIFO_DATA,
  output logic [grant_width(NUM_REQ)-1:0] GRANT_ID,
  output logic                          BUSY
);

  localparam int GW = grant_width(NUM_REQ);
  localparam int CW = cnt_width(MAX_BURST);

  // Handshake: a beat of requester k transfers on a WR_CLK edge where
  // REQ_VALID[k] && REQ_READY[k]; READY only rises for the granted requester
  // in XFER while the FIFO is not full, and each transfer is one FIFO write.
  arb_state_t    state;
  logic [GW-1:0] grant;
  logic [GW-1:0] last_grant;
  logic [CW-1:0] beat_cnt;
  logic [GW-1:0] winner;
  logic          any_req;
  logic          accept;
  logic          burst_end;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_picker (
    .req        (REQ_VALID),
    .last_grant (last_grant),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign accept    = (state == XFER) && REQ_VALID[grant] && !FIFO_FULL;
  assign burst_end = accept && (REQ_LAST[grant] || (beat_cnt == CW'(MAX_BURST - 1)));

  always_ff @(posedge WR_CLK or negedge FRSTN) begin
    if (!FRSTN) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant    <= winner;
            beat_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (accept) beat_cnt <= beat_cnt + 1'b1;
          if (burst_end) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Async reset forces state to IDLE, which zeroes every output below at once.
  always_comb begin
    REQ_READY = '0;
    FIFO_DATA = '0;
    if (state == XFER) begin
      REQ_READY[grant] = !FIFO_FULL;
      FIFO_DATA        = REQ_DATA[grant*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign FIFO_WR_EN = accept;
  assign BUSY       = (state == XFER);
  assign GRANT_ID   = grant;

endmodule

// File: tb/tb_async_fifo_write_arbiter.sv
// Directed bench for async_fifo_write_arbiter: per-requester beat sources,
// a per-cycle write log, and hand-computed write sequences per scenario.
module tb_async_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic            clk;
  logic            frstn;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data;
  logic [1:0]      grant_id;
  logic            busy;

  async_fifo_write_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (16)
  ) dut (
    .WR_CLK     (clk),
    .FRSTN      (frstn),
    .REQ_VALID  (req_valid),
    .REQ_DATA   (req_data),
    .REQ_LAST   (req_last),
    .REQ_READY  (req_ready),
    .FIFO_FULL  (fifo_full),
    .FIFO_WR_EN (fifo_wr_en),
    .FIFO_DATA  (fifo_data),
    .GRANT_ID   (grant_id),
    .BUSY       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] sd [NR][32];
  logic       sl [NR][32];
  int         scnt [NR];
  int         sptr [NR];
  logic       hold [NR];
  logic       full;

  int         cyc;
  logic       busy_log [256];
  logic [1:0] gid_log  [256];
  logic [3:0] rdy_log  [256];
  logic       wen_log  [256];
  int         wr_cyc_q  [$];
  logic [7:0] wr_data_q [$];
  logic [1:0] wr_gid_q  [$];

  // driver tasks
  task automatic load_beat(input int k, input logic [7:0] d, input logic l);
    sd[k][scnt[k]] = d;
    sl[k][scnt[k]] = l;
    scnt[k]++;
  endtask

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      if (sptr[k] < scnt[k] && !hold[k]) begin
        req_valid[k]        = 1'b1;
        req_data[k*DW +: DW] = sd[k][sptr[k]];
        req_last[k]         = sl[k][sptr[k]];
      end else begin
        req_valid[k]        = 1'b0;
        req_data[k*DW +: DW] = 8'hEE;
        req_last[k]         = 1'b1;
      end
    end
    fifo_full = full;
  endtask

  task automatic cycle();
    drive();
    #1;
    if (cyc < 256) begin
      busy_log[cyc] = busy;
      gid_log[cyc]  = grant_id;
      rdy_log[cyc]  = req_ready;
      wen_log[cyc]  = fifo_wr_en;
    end
    if (fifo_wr_en) begin
      wr_cyc_q.push_back(cyc);
      wr_data_q.push_back(fifo_data);
      wr_gid_q.push_back(grant_id);
    end
    for (int k = 0; k < NR; k++)
      if (req_valid[k] && req_ready[k]) sptr[k]++;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_sources();
    for (int k = 0; k < NR; k++) begin
      scnt[k] = 0;
      sptr[k] = 0;
      hold[k] = 1'b0;
    end
    full = 1'b0;
  endtask

  task automatic clear_log();
    cyc = 0;
    wr_cyc_q.delete();
    wr_data_q.delete();
    wr_gid_q.delete();
  endtask

  task automatic reset_dut();
    frstn = 1'b0;
    clear_sources();
    drive();
    @(negedge clk);
    @(negedge clk);
    frstn = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    frstn = 1'b0;
    clear_sources();
    for (int k = 0; k < NR; k++) load_beat(k, 8'h11, 1'b1);
    drive();
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++;
    if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", fifo_wr_en); end
    checks++;
    if (fifo_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", fifo_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
      errors++; $display("FAIL reset_hold: busy %b wr_en %b expected 0 0", busy, fifo_wr_en);
    end
  endtask

  task automatic test_single();
    int         ec [3] = '{1, 2, 3};
    logic [7:0] ed [3] = '{8'hA1, 8'hA2, 8'hA3};
    reset_dut();
    load_beat(1, 8'hA1, 1'b0);
    load_beat(1, 8'hA2, 1'b0);
    load_beat(1, 8'hA3, 1'b1);
    for (int t = 0; t < 6; t++) cycle();
    checks++;
    if (busy_log[0] !== 1'b0 || rdy_log[0] !== 4'b0000) begin
      errors++; $display("FAIL single_bubble: busy %b ready %b expected 0 0000", busy_log[0], rdy_log[0]);
    end
    checks++;
    if (gid_log[1] !== 2'd1) begin errors++; $display("FAIL single_grant: got %0d expected 1", gid_log[1]); end
    checks++;
    if (wr_data_q.size() != 3) begin errors++; $display("FAIL single_count: got %0d expected 3", wr_data_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wr_data_q.size() || wr_data_q[i] !== ed[i] || wr_cyc_q[i] != ec[i] || wr_gid_q[i] !== 2'd1) begin
        errors++;
        $display("FAIL single_write%0d: got data %h cyc %0d expected data %h cyc %0d", i,
                 (i < wr_data_q.size()) ? wr_data_q[i] : 8'hxx, (i < wr_cyc_q.size()) ? wr_cyc_q[i] : -1, ed[i], ec[i]);
      end
    end
    checks++;
    if (busy_log[4] !== 1'b0) begin errors++; $display("FAIL single_idle: busy %b expected 0", busy_log[4]); end
  endtask

  task automatic test_round_robin();
    int         ec [5] = '{1, 3, 5, 7, 9};
    logic [7:0] ed [5] = '{8'h80, 8'h90, 8'hA0, 8'hB0, 8'h81};
    logic [1:0] eg [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    reset_dut();
    for (int k = 0; k < NR; k++) begin
      load_beat(k, 8'(8'h80 + 16*k), 1'b1);
      load_beat(k, 8'(8'h81 + 16*k), 1'b1);
    end
    for (int t = 0; t < 10; t++) cycle();
    checks++;
    if (wr_data_q.size() != 5) begin errors++; $display("FAIL rr_count: got %0d expected 5", wr_data_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= wr_data_q.size() || wr_data_q[i] !== ed[i] || wr_cyc_q[i] != ec[i] || wr_gid_q[i] !== eg[i]) begin
        errors++;
        $display("FAIL rr_write%0d: got data %h cyc %0d expected data %h cyc %0d grant %0d", i,
                 (i < wr_data_q.size()) ? wr_data_q[i] : 8'hxx, (i < wr_cyc_q.size()) ? wr_cyc_q[i] : -1, ed[i], ec[i], eg[i]);
      end
    end
    for (int t = 2; t <= 8; t += 2) begin
      checks++;
      if (busy_log[t] !== 1'b0) begin errors++; $display("FAIL rr_gap%0d: busy %b expected 0", t, busy_log[t]); end
    end
  endtask

  task automatic test_burst_limit();
    int         ec [21];
    logic [7:0] ed [21];
    logic [1:0] eg [21];
    reset_dut();
    for (int n = 0; n < 20; n++) load_beat(2, 8'(8'h20 + n), 1'b0);
    load_beat(3, 8'hC0, 1'b1);
    for (int i = 0; i < 16; i++) begin ec[i] = i + 1; ed[i] = 8'(8'h20 + i); eg[i] = 2'd2; end
    ec[16] = 18; ed[16] = 8'hC0; eg[16] = 2'd3;
    for (int i = 0; i < 4; i++) begin ec[17+i] = 20 + i; ed[17+i] = 8'(8'h30 + i); eg[17+i] = 2'd2; end
    for (int t = 0; t < 27; t++) cycle();
    checks++;
    if (wr_data_q.size() != 21) begin errors++; $display("FAIL burst_count: got %0d expected 21", wr_data_q.size()); end
    for (int i = 0; i < 21; i++) begin
      checks++;
      if (i >= wr_data_q.size() || wr_data_q[i] !== ed[i] || wr_cyc_q[i] != ec[i] || wr_gid_q[i] !== eg[i]) begin
        errors++;
        $display("FAIL burst_write%0d: got data %h cyc %0d expected data %h cyc %0d grant %0d", i,
                 (i < wr_data_q.size()) ? wr_data_q[i] : 8'hxx, (i < wr_cyc_q.size()) ? wr_cyc_q[i] : -1, ed[i], ec[i], eg[i]);
      end
    end
    checks++;
    if (busy_log[17] !== 1'b0 || busy_log[19] !== 1'b0) begin
      errors++; $display("FAIL burst_gaps: busy %b %b expected 0 0", busy_log[17], busy_log[19]);
    end
  endtask

  task automatic test_full_stall();
    int         ec [4] = '{1, 2, 8, 9};
    logic [7:0] ed [4] = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    reset_dut();
    for (int n = 0; n < 4; n++) load_beat(0, 8'(8'hD0 + n), n == 3);
    for (int t = 0; t < 12; t++) begin
      full = (t >= 3 && t <= 7);
      cycle();
    end
    full = 1'b0;
    for (int t = 3; t <= 7; t++) begin
      checks++;
      if (wen_log[t] !== 1'b0 || rdy_log[t] !== 4'b0000 || busy_log[t] !== 1'b1) begin
        errors++;
        $display("FAIL full_stall%0d: wr_en %b ready %b busy %b expected 0 0000 1", t, wen_log[t], rdy_log[t], busy_log[t]);
      end
    end
    checks++;
    if (wr_data_q.size() != 4) begin errors++; $display("FAIL full_count: got %0d expected 4", wr_data_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= wr_data_q.size() || wr_data_q[i] !== ed[i] || wr_cyc_q[i] != ec[i]) begin
        errors++;
        $display("FAIL full_write%0d: got data %h cyc %0d expected data %h cyc %0d", i,
                 (i < wr_data_q.size()) ? wr_data_q[i] : 8'hxx, (i < wr_cyc_q.size()) ? wr_cyc_q[i] : -1, ed[i], ec[i]);
      end
    end
  endtask

  task automatic test_valid_drop();
    int         ec [5] = '{1, 2, 6, 7, 9};
    logic [7:0] ed [5] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h05};
    logic [1:0] eg [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    reset_dut();
    for (int n = 0; n < 4; n++) load_beat(1, 8'(8'h40 + n), n == 3);
    for (int t = 0; t < 11; t++) begin
      hold[1] = (t >= 3 && t <= 5);
      if (t == 3) load_beat(0, 8'h05, 1'b1);
      cycle();
    end
    hold[1] = 1'b0;
    for (int t = 3; t <= 5; t++) begin
      checks++;
      if (gid_log[t] !== 2'd1 || busy_log[t] !== 1'b1 || wen_log[t] !== 1'b0) begin
        errors++;
        $display("FAIL drop_hold%0d: grant %0d busy %b wr_en %b expected 1 1 0", t, gid_log[t], busy_log[t], wen_log[t]);
      end
    end
    checks++;
    if (wr_data_q.size() != 5) begin errors++; $display("FAIL drop_count: got %0d expected 5", wr_data_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= wr_data_q.size() || wr_data_q[i] !== ed[i] || wr_cyc_q[i] != ec[i] || wr_gid_q[i] !== eg[i]) begin
        errors++;
        $display("FAIL drop_write%0d: got data %h cyc %0d expected data %h cyc %0d grant %0d", i,
                 (i < wr_data_q.size()) ? wr_data_q[i] : 8'hxx, (i < wr_cyc_q.size()) ? wr_cyc_q[i] : -1, ed[i], ec[i], eg[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int         ec [2] = '{1, 3};
    logic [7:0] ed [2] = '{8'h70, 8'h61};
    logic [1:0] eg [2] = '{2'd0, 2'd2};
    reset_dut();
    for (int n = 0; n < 4; n++) load_beat(2, 8'(8'h60 + n), n == 3);
    cycle();
    cycle();
    drive();
    frstn = 1'b0;
    #1;
    checks++;
    if (fifo_wr_en !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL midrst_outputs: wr_en %b busy %b ready %b grant %0d expected 0 0 0000 0", fifo_wr_en, busy, req_ready, grant_id);
    end
    checks++;
    if (wr_data_q.size() != 1 || wr_data_q[0] !== 8'h60) begin
      errors++; $display("FAIL midrst_prior: got %0d writes expected 1 (data 60)", wr_data_q.size());
    end
    @(posedge clk);
    @(negedge clk);
    frstn = 1'b1;
    clear_log();
    load_beat(0, 8'h70, 1'b1);
    for (int t = 0; t < 4; t++) cycle();
    checks++;
    if (wr_data_q.size() != 2) begin errors++; $display("FAIL midrst_count: got %0d expected 2", wr_data_q.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= wr_data_q.size() || wr_data_q[i] !== ed[i] || wr_cyc_q[i] != ec[i] || wr_gid_q[i] !== eg[i]) begin
        errors++;
        $display("FAIL midrst_write%0d: got data %h cyc %0d expected data %h cyc %0d grant %0d", i,
                 (i < wr_data_q.size()) ? wr_data_q[i] : 8'hxx, (i < wr_cyc_q.size()) ? wr_cyc_q[i] : -1, ed[i], ec[i], eg[i]);
      end
    end
  endtask

  initial begin
    frstn     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    cyc       = 0;
    clear_sources();
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_burst_limit();
    test_full_stall();
    test_valid_drop();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
